// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
//   Shared types and constants for the FIR control front-end.
//   - state_t  : sequencer states
//   - opcode_t : command opcodes carried in cmd_data[7:6]
//   - default parameter values and fixed widths
//   - decode_op: extracts the opcode from a command byte
// -----------------------------------------------------------------------------
package fir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_RUN    = 3'd3,
        ST_FLUSH  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_LOAD = 2'b01,
        OP_RUN  = 2'b10,
        OP_STOP = 2'b11
    } opcode_t;

    localparam int DEF_NUM_TAPS = 4;
    localparam int DEF_COEFF_W  = 8;
    localparam int DEF_DATA_W   = 6;
    localparam int DEF_TIMEOUT  = 255;

    localparam int CMD_W  = 8;
    localparam int DROP_W = 8;

    function automatic opcode_t decode_op(input logic [CMD_W-1:0] cmd);
        return opcode_t'(cmd[7:6]);
    endfunction

endpackage

// File: rtl/fir_ctrl_timer.sv
// -----------------------------------------------------------------------------
// fir_ctrl_timer
//   Generic cycle counter with synchronous clear. While enable is high the
//   count advances once per cycle; expire is high in the cycle where an
//   enabled count has reached 'last', i.e. on the (last+1)-th enabled cycle
//   since the most recent clear.
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (wins over enable)
//   enable     : advance the count this cycle
//   last       : terminal count value
//   count      : current count
//   expire     : terminal count reached in an enabled cycle
// -----------------------------------------------------------------------------
module fir_ctrl_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] last,
    output logic [WIDTH-1:0] count,
    output logic             expire
);

    assign expire = enable && !clear && (count == last);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fir_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// fir_ctrl_sequencer
//   Command-driven control front-end for the FIR datapath. Loads NUM_TAPS
//   coefficients, pulses the coefficient commit strobe, gates samples to the
//   FIR while running and flushes the FIR delay line with zeros on STOP.
// Ports
//   clk, rst_n                   : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_data : byte command stream (valid/ready handshake)
//   smp_valid/smp_data           : input samples (no backpressure)
//   fir_x_n/fir_tvalid           : sample and strobe to the FIR (1-cycle latency)
//   fir_set_coeffs               : one-cycle coefficient commit strobe
//   coeff_wr_en/addr/data        : coefficient store write port
//   running                      : high while in RUN
//   err                          : sticky error (cleared by NOP with bit0 set)
//   drop_cnt                     : saturating count of samples dropped outside RUN
// All outputs are registered.
// -----------------------------------------------------------------------------
module fir_ctrl_sequencer
    import fir_pkg::*;
#(
    parameter int NUM_TAPS = DEF_NUM_TAPS,
    parameter int COEFF_W  = DEF_COEFF_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    localparam int ADDR_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [CMD_W-1:0]   cmd_data,
    input  logic               smp_valid,
    input  logic [DATA_W-1:0]  smp_data,
    output logic [DATA_W-1:0]  fir_x_n,
    output logic               fir_tvalid,
    output logic               fir_set_coeffs,
    output logic               coeff_wr_en,
    output logic [ADDR_W-1:0]  coeff_wr_addr,
    output logic [COEFF_W-1:0] coeff_wr_data,
    output logic               running,
    output logic               err,
    output logic [DROP_W-1:0]  drop_cnt
);

    // One timer serves both the LOAD idle timeout and the FLUSH length.
    localparam int TMR_MAX = (TIMEOUT > NUM_TAPS) ? TIMEOUT : NUM_TAPS;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t             state, next_state;
    logic [ADDR_W-1:0]  idx, idx_nxt;
    logic               accept;
    opcode_t            op;

    logic               tmr_en, tmr_expire;
    logic [TMR_W-1:0]   tmr_last, tmr_count;

    logic               cmd_ready_nxt, running_nxt, err_nxt;
    logic               set_coeffs_nxt, wr_en_nxt, tvalid_nxt;
    logic [ADDR_W-1:0]  wr_addr_nxt;
    logic [COEFF_W-1:0] wr_data_nxt;
    logic [DATA_W-1:0]  x_n_nxt;
    logic [DROP_W-1:0]  drop_nxt;

    assign accept = cmd_valid && cmd_ready;
    assign op     = decode_op(cmd_data);

    // In LOAD the timer counts only idle cycles; any accepted byte restarts it.
    assign tmr_en   = ((state == ST_LOAD) && !accept) || (state == ST_FLUSH);
    assign tmr_last = (state == ST_FLUSH) ? TMR_W'(NUM_TAPS - 1) : TMR_W'(TIMEOUT - 1);

    fir_ctrl_timer #(.WIDTH(TMR_W)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (!tmr_en),
        .enable (tmr_en),
        .last   (tmr_last),
        .count  (tmr_count),
        .expire (tmr_expire)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    // NOTE: every variable written in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (accept && op == OP_LOAD) next_state = ST_LOAD;
                else if (accept && op == OP_RUN) next_state = ST_RUN;
            end
            ST_LOAD: begin
                if (accept && idx == ADDR_W'(NUM_TAPS - 1)) next_state = ST_COMMIT;
                else if (tmr_expire)                         next_state = ST_IDLE;
            end
            ST_COMMIT: next_state = ST_IDLE;
            ST_RUN: begin
                if (accept && op == OP_STOP) next_state = ST_FLUSH;
            end
            ST_FLUSH: begin
                if (tmr_expire) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        cmd_ready_nxt  = (next_state == ST_IDLE) || (next_state == ST_LOAD) ||
                         (next_state == ST_RUN);
        running_nxt    = (next_state == ST_RUN);
        set_coeffs_nxt = (state == ST_LOAD) && (next_state == ST_COMMIT);
        wr_en_nxt      = 1'b0;
        wr_addr_nxt    = coeff_wr_addr;
        wr_data_nxt    = coeff_wr_data;
        idx_nxt        = idx;
        tvalid_nxt     = 1'b0;
        x_n_nxt        = fir_x_n;
        err_nxt        = err;
        drop_nxt       = drop_cnt;

        unique case (state)
            ST_IDLE: begin
                idx_nxt = '0;
                if (accept && op == OP_NOP && cmd_data[0]) err_nxt = 1'b0;
            end
            ST_LOAD: begin
                if (accept) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = idx;
                    wr_data_nxt = cmd_data[COEFF_W-1:0];
                    idx_nxt     = idx + 1'b1;
                end else if (tmr_expire) begin
                    err_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                tvalid_nxt = smp_valid;
                if (smp_valid) x_n_nxt = smp_data;
                if (accept && op == OP_NOP && cmd_data[0]) err_nxt = 1'b0;
                if (accept && op == OP_LOAD)               err_nxt = 1'b1;
            end
            ST_FLUSH: begin
                tvalid_nxt = 1'b1;
                x_n_nxt    = '0;
            end
            default: ;
        endcase

        if (smp_valid && state != ST_RUN && drop_cnt != '1) begin
            drop_nxt = drop_cnt + 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready      <= 1'b1;
            running        <= 1'b0;
            fir_set_coeffs <= 1'b0;
            coeff_wr_en    <= 1'b0;
            coeff_wr_addr  <= '0;
            coeff_wr_data  <= '0;
            idx            <= '0;
            fir_tvalid     <= 1'b0;
            fir_x_n        <= '0;
            err            <= 1'b0;
            drop_cnt       <= '0;
        end else begin
            cmd_ready      <= cmd_ready_nxt;
            running        <= running_nxt;
            fir_set_coeffs <= set_coeffs_nxt;
            coeff_wr_en    <= wr_en_nxt;
            coeff_wr_addr  <= wr_addr_nxt;
            coeff_wr_data  <= wr_data_nxt;
            idx            <= idx_nxt;
            fir_tvalid     <= tvalid_nxt;
            fir_x_n        <= x_n_nxt;
            err            <= err_nxt;
            drop_cnt       <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_fir_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fir_ctrl_sequencer
//   Directed bench for fir_ctrl_sequencer. Inputs change 1 time unit after a
//   rising edge; outputs are sampled at the same point, so each sample shows
//   the result of the previous clock cycle.
// -----------------------------------------------------------------------------
module tb_fir_ctrl_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic       smp_valid;
    logic [5:0] smp_data;
    logic [5:0] fir_x_n;
    logic       fir_tvalid;
    logic       fir_set_coeffs;
    logic       coeff_wr_en;
    logic [1:0] coeff_wr_addr;
    logic [7:0] coeff_wr_data;
    logic       running;
    logic       err;
    logic [7:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    int sc_pulses = 0;

    logic [7:0] coefs [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    fir_ctrl_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_data       (cmd_data),
        .smp_valid      (smp_valid),
        .smp_data       (smp_data),
        .fir_x_n        (fir_x_n),
        .fir_tvalid     (fir_tvalid),
        .fir_set_coeffs (fir_set_coeffs),
        .coeff_wr_en    (coeff_wr_en),
        .coeff_wr_addr  (coeff_wr_addr),
        .coeff_wr_data  (coeff_wr_data),
        .running        (running),
        .err            (err),
        .drop_cnt       (drop_cnt)
    );

    always #5 clk = ~clk;

    // Count cycles in which the commit strobe is high.
    always @(posedge clk) begin
        if (fir_set_coeffs === 1'b1) sc_pulses++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        cmd_valid = 1'b1;
        cmd_data  = b;
        cyc();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_data  = '0;
        smp_valid = 1'b0;
        smp_data  = '0;
        cyc();
        cyc();

        // Reset values
        check("rst_ready", cmd_ready, 1);
        check("rst_others", {fir_x_n, fir_tvalid, fir_set_coeffs, coeff_wr_en,
                             coeff_wr_addr, coeff_wr_data, running, err, drop_cnt}, 0);
        rst_n = 1'b1;
        cyc();
        check("idle_ready", cmd_ready, 1);
        check("idle_others", {fir_tvalid, fir_set_coeffs, coeff_wr_en, running, err}, 0);

        // LOAD 0x11..0x44 then commit
        cmd_valid = 1'b1;
        cmd_data  = 8'h40;
        cyc();
        check("load_enter_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cmd_data = coefs[i];
            cyc();
            check($sformatf("wr%0d", i), {coeff_wr_en, coeff_wr_addr, coeff_wr_data},
                  {1'b1, 2'(i), coefs[i]});
        end
        cmd_valid = 1'b0;
        check("commit_pulse", fir_set_coeffs, 1);
        check("commit_ready", cmd_ready, 0);
        cyc();
        check("post_commit", {fir_set_coeffs, coeff_wr_en, cmd_ready}, 3'b001);
        check("commit_count", sc_pulses, 1);

        // RUN with samples 5, 9, 63, gap, then STOP with sample 7
        send(8'h80);
        check("running", {running, cmd_ready}, 2'b11);
        smp_valid = 1'b1;
        smp_data = 6'd5;  cyc(); check("smp5",  {fir_tvalid, fir_x_n}, {1'b1, 6'd5});
        smp_data = 6'd9;  cyc(); check("smp9",  {fir_tvalid, fir_x_n}, {1'b1, 6'd9});
        smp_data = 6'd63; cyc(); check("smp63", {fir_tvalid, fir_x_n}, {1'b1, 6'd63});
        smp_valid = 1'b0;
        smp_data  = 6'd1;
        cyc();
        check("gap_hold", {fir_tvalid, fir_x_n}, {1'b0, 6'd63});
        smp_valid = 1'b1;
        smp_data  = 6'd7;
        cmd_valid = 1'b1;
        cmd_data  = 8'hC0;
        cyc();
        cmd_valid = 1'b0;
        smp_valid = 1'b0;
        check("stop_smp7", {fir_tvalid, fir_x_n}, {1'b1, 6'd7});
        check("flush_state", {running, cmd_ready}, 2'b00);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check($sformatf("flush%0d", i), {fir_tvalid, fir_x_n}, {1'b1, 6'd0});
        end
        check("flush_done_ready", cmd_ready, 1);
        cyc();
        check("after_flush", {fir_tvalid, fir_x_n, running}, 0);
        check("no_drops_yet", drop_cnt, 0);

        // LOAD timeout after two bytes
        send(8'h40);
        send(8'hA1);
        send(8'hA2);
        repeat (254) cyc();
        check("stall254_err", {err, cmd_ready}, 2'b01);
        cyc();
        check("timeout_err", err, 1);
        check("timeout_no_commit", sc_pulses, 1);
        send(8'h01);
        check("nop_clear", err, 0);
        check("idle_not_load", coeff_wr_en, 0);

        // Drop counter saturation in IDLE
        smp_valid = 1'b1;
        smp_data  = 6'd3;
        repeat (254) cyc();
        check("drop254", drop_cnt, 254);
        repeat (46) cyc();
        check("drop_sat", drop_cnt, 255);
        smp_valid = 1'b0;

        // LOAD rejected in RUN
        send(8'h80);
        send(8'h40);
        check("load_in_run", {err, running, cmd_ready}, 3'b111);
        send(8'h01);
        check("nop_clear_run", {err, running}, 2'b01);
        send(8'h80);
        check("run_in_run", {running, coeff_wr_en}, 2'b10);

        // Reset during FLUSH
        send(8'hC0);
        cyc();
        rst_n = 1'b0;
        #1;
        check("rst_flush", {fir_tvalid, running, cmd_ready, drop_cnt}, {3'b001, 8'd0});
        cyc();
        rst_n = 1'b1;
        cyc();

        // Reset during LOAD: no commit afterwards
        send(8'h40);
        send(8'h55);
        rst_n = 1'b0;
        #1;
        check("rst_load", {coeff_wr_en, coeff_wr_addr, coeff_wr_data, cmd_ready}, 12'h001);
        cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        check("rst_load_no_commit", sc_pulses, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
